mvau_inp_replay_buffer: RTL and testbench
=========================================

# mvau_inp_replay_buffer

Input activation buffer that sits directly upstream of the MVAU compute datapath and its weight-address control block. On the first filter-bank pass it accepts SF input words from the activation stream, stores them, and forwards them to the datapath. It then replays the stored row NF-1 more times while the input stream is held off. Output words carry a row-end marker, so downstream accumulators and the weight-address counter stay aligned with the (sf, nf) iteration order.

## Interface
Parameters:
- SF, 8: input words per weight-matrix row (matrix width / SIMD); must be ≥ 1.
- NF, 8: filter-bank passes per input row (matrix height / PE); must be ≥ 1.
- SIMD, 2: activation elements per word.
- TSRCI, 4: bits per activation element.
- IN_W, SIMD*TSRCI: word width; derived, not to be overridden.

Ports:
- aclk, input, 1: main clock.
- aresetn, input, 1: reset, synchronous, active-low.
- in_dat, input, IN_W: input activation word.
- in_v, input, 1: input word valid.
- in_rdy, output, 1: buffer ready for an input word.
- out_dat, output, IN_W: activation word sent to the datapath.
- out_v, output, 1: out_dat valid.
- out_rdy, input, 1: datapath accepts out_dat.
- out_sf_last, output, 1: out_dat is word SF-1 of its row (accumulator clear for the next cycle).
- out_nf_last, output, 1: out_dat belongs to pass NF-1 (last replay of this row).

## Operation
- State machine, two states:
  - FILL: forward the input stream and store it.
  - REPLAY: output from buffer storage.
  - Reset state is FILL.
- Counters:
  - sf_cnt has width max(1, $clog2(SF)) and counts 0..SF-1.
  - nf_cnt has width max(1, $clog2(NF)) and counts 0..NF-1.
  - Both wrap to 0 by explicit compare against SF-1 / NF-1, never by natural overflow.
- Advance enable: adv = !out_v | out_rdy.
- FILL:
  - in_rdy = adv.
  - On in_v & in_rdy: write in_dat to buf[sf_cnt], load the output register with in_dat, and increment sf_cnt.
  - When the accepted word has sf_cnt==SF-1: sf_cnt←0. If NF>1, go to REPLAY with nf_cnt←1; otherwise stay in FILL with nf_cnt 0.
- REPLAY:
  - in_rdy = 0.
  - On adv: load the output register with buf[sf_cnt] and increment sf_cnt.
  - At sf_cnt==SF-1: sf_cnt←0. Then if nf_cnt==NF-1, set nf_cnt←0 and go to FILL; otherwise increment nf_cnt.
- Marker flags are registered alongside out_dat:
  - out_sf_last = (sf_cnt==SF-1) at load.
  - out_nf_last = (nf_cnt==NF-1) at load.
- NF==1: REPLAY is unreachable, and the buffer is still written (harmless).
- SF==1: every word is row-last; sf_cnt stays 0.
- Buffer storage is a register array of SF×IN_W with combinational read. It is not reset.

## Timing
- Reset values: out_v 0, out_dat 0, out_sf_last 0, out_nf_last 0, in_rdy 0 during reset. Internally, sf_cnt 0, nf_cnt 0, state FILL.
- Latency is 1 cycle: a word accepted at edge k is visible on out_dat with out_v=1 after edge k.
- Throughput is one word/cycle in both states when out_rdy is held 1. There are no bubbles at the FILL→REPLAY and REPLAY→FILL transitions.
- Output stall: while out_v & !out_rdy, the output register, counters and state hold, and in_rdy=0.
- out_v clears only when out_rdy is high and no new load occurs (FILL with in_v=0).
- Simultaneous events:
  - The last REPLAY word is loaded in the same cycle the state returns to FILL.
  - The first new input can be accepted on the next edge.
- Reset mid-operation: counters and state return to reset values at the next edge and out_v drops. Partial rows are discarded. Buffer contents are undefined until rewritten.

## Structure
- Shared package mvau_defn holds:
  - the state typedef enum {FILL, REPLAY};
  - helper function cnt_w(n) = max(1, $clog2(n)), also used by the control block.
- Sub-module mvau_inp_replay_mem: SF-deep, IN_W-wide register array with write port (we, waddr, wdat) and combinational read port (raddr, rdat).
- Top level holds the FSM, counters and output register.

## Test plan
- SF=4, NF=3, IN_W=8, out_rdy=1, inputs 0x11,0x22,0x33,0x44 streamed back-to-back:
  - out_dat is 0x11..0x44 three times over 12 consecutive cycles.
  - out_sf_last is high on every 0x44.
  - out_nf_last is high on the third pass only.
  - in_rdy is low during cycles 5–12.
- Same config, two rows back-to-back (second row 0x55..0x88): first output of row 2 appears the cycle after the last replay of row 1, with no gap.
- Random out_rdy (50%): output sequence is identical to the first scenario, and out_dat is stable while out_v & !out_rdy.
- NF=1, SF=4: in_rdy stays high, output is a 1-cycle-delayed pass-through, and out_nf_last=1 on every word.
- SF=1, NF=2: each input is output twice, with out_sf_last=1 on every word.
- Reset asserted during pass 2 of the first scenario: the next cycle shows out_v=0 and in_rdy=1 after release, and a fresh row 0xA1..0xA4 replays correctly.

Source files
------------

// File: rtl/mvau_defn.sv
// Shared MVAU definitions: replay-buffer state encoding and the counter width helper.
package mvau_defn;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Counter width for a 0..n-1 counter; a single-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvau_inp_replay_mem.sv
// SF-deep activation row storage: one write port, one combinational read port.
module mvau_inp_replay_mem
  import mvau_defn::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          aclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every entry is written in FILL before REPLAY reads it.
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/mvau_inp_replay_buffer.sv
// MVAU input buffer: forwards one activation row, then replays it NF-1 times
// with sf/nf row markers so downstream accumulators and weight addressing stay aligned.
module mvau_inp_replay_buffer
  import mvau_defn::*;
#(
  parameter int SF    = 8,
  parameter int NF    = 8,
  parameter int SIMD  = 2,
  parameter int TSRCI = 4,
  parameter int IN_W  = SIMD * TSRCI
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [IN_W-1:0] in_dat,
  input  logic            in_v,
  output logic            in_rdy,
  output logic [IN_W-1:0] out_dat,
  output logic            out_v,
  input  logic            out_rdy,
  output logic            out_sf_last,
  output logic            out_nf_last
);

  localparam int SF_W = cnt_w(SF);
  localparam int NF_W = cnt_w(NF);
  localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);

  state_e          state, state_nxt;
  logic [SF_W-1:0] sf_cnt, sf_nxt;
  logic [NF_W-1:0] nf_cnt, nf_nxt;
  logic            adv, load, wr, out_v_nxt;
  logic            sf_end, nf_end;
  logic [IN_W-1:0] rd_dat, load_dat;

  assign adv    = !out_v | out_rdy;
  assign sf_end = (sf_cnt == SF_MAX);
  assign nf_end = (nf_cnt == NF_MAX);

  mvau_inp_replay_mem #(
    .DEPTH (SF),
    .W     (IN_W),
    .AW    (SF_W)
  ) u_mem (
    .aclk  (aclk),
    .we    (wr),
    .waddr (sf_cnt),
    .wdat  (in_dat),
    .raddr (sf_cnt),
    .rdat  (rd_dat)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    sf_nxt    = sf_cnt;
    nf_nxt    = nf_cnt;
    in_rdy    = 1'b0;
    load      = 1'b0;
    load_dat  = rd_dat;
    wr        = 1'b0;
    out_v_nxt = out_v;

    case (state)
      FILL: begin
        in_rdy = adv & aresetn;
        if (adv) out_v_nxt = 1'b0;
        if (in_v && in_rdy) begin
          wr        = 1'b1;
          load      = 1'b1;
          load_dat  = in_dat;
          out_v_nxt = 1'b1;
          if (sf_end) begin
            sf_nxt = '0;
            if (NF > 1) begin
              state_nxt = REPLAY;
              nf_nxt    = NF_W'(1);
            end else begin
              nf_nxt = '0;
            end
          end else begin
            sf_nxt = sf_cnt + SF_W'(1);
          end
        end
      end

      REPLAY: begin
        if (adv) begin
          load      = 1'b1;
          out_v_nxt = 1'b1;
          if (sf_end) begin
            sf_nxt = '0;
            if (nf_end) begin
              nf_nxt    = '0;
              state_nxt = FILL;
            end else begin
              nf_nxt = nf_cnt + NF_W'(1);
            end
          end else begin
            sf_nxt = sf_cnt + SF_W'(1);
          end
        end
      end

      default: state_nxt = FILL;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous); state updates use <= only.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= FILL;
      sf_cnt      <= '0;
      nf_cnt      <= '0;
      out_v       <= 1'b0;
      out_dat     <= '0;
      out_sf_last <= 1'b0;
      out_nf_last <= 1'b0;
    end else begin
      state  <= state_nxt;
      sf_cnt <= sf_nxt;
      nf_cnt <= nf_nxt;
      out_v  <= out_v_nxt;
      if (load) begin
        out_dat     <= load_dat;
        out_sf_last <= sf_end;
        out_nf_last <= nf_end;
      end
    end
  end

endmodule

// File: tb/tb_mvau_inp_replay_buffer.sv
// Bench for mvau_inp_replay_buffer: cycle-exact vector table plus a scoreboard
// across three configurations (SF=4/NF=3, SF=4/NF=1, SF=1/NF=2).
module tb_mvau_inp_replay_buffer;

  localparam int SF_T[3] = '{4, 4, 1};
  localparam int NF_T[3] = '{3, 1, 2};

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] in_dat  = '0;
  logic       in_v    = 1'b0;
  logic       out_rdy = 1'b1;

  logic       in_rdy_a  [3];
  logic       out_v_a   [3];
  logic       sfl_a     [3];
  logic       nfl_a     [3];
  logic [7:0] out_dat_a [3];

  always #5 aclk = ~aclk;

  mvau_inp_replay_buffer #(.SF(4), .NF(3), .SIMD(2), .TSRCI(4)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .in_dat(in_dat), .in_v(in_v), .in_rdy(in_rdy_a[0]),
    .out_dat(out_dat_a[0]), .out_v(out_v_a[0]), .out_rdy(out_rdy),
    .out_sf_last(sfl_a[0]), .out_nf_last(nfl_a[0]));

  mvau_inp_replay_buffer #(.SF(4), .NF(1), .SIMD(2), .TSRCI(4)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .in_dat(in_dat), .in_v(in_v), .in_rdy(in_rdy_a[1]),
    .out_dat(out_dat_a[1]), .out_v(out_v_a[1]), .out_rdy(out_rdy),
    .out_sf_last(sfl_a[1]), .out_nf_last(nfl_a[1]));

  mvau_inp_replay_buffer #(.SF(1), .NF(2), .SIMD(2), .TSRCI(4)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .in_dat(in_dat), .in_v(in_v), .in_rdy(in_rdy_a[2]),
    .out_dat(out_dat_a[2]), .out_v(out_v_a[2]), .out_rdy(out_rdy),
    .out_sf_last(sfl_a[2]), .out_nf_last(nfl_a[2]));

  typedef struct {
    logic [7:0] dat;
    logic       sfl;
    logic       nfl;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] dat;
    logic       exp_rdy;
    logic [7:0] exp_dat;
    logic       exp_sfl;
    logic       exp_nfl;
  } vec_t;

  exp_t       sb[$];
  logic [7:0] stim[$];
  vec_t       tbl[12];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int first_pop = -1;
  int last_pop  = -1;
  int cur   = 0;
  bit mon_en = 1'b0;
  bit rnd_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    if (rnd_en) begin
      #1 out_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Every valid cycle, including stalled ones, must show the head of the scoreboard.
  always @(negedge aclk) begin
    if (mon_en && out_v_a[cur]) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got out_dat 0x%0h, expected no output", out_dat_a[cur]);
      end else begin
        check("sb_dat", 32'(out_dat_a[cur]), 32'(sb[0].dat));
        check("sb_sf_last", 32'(sfl_a[cur]), 32'(sb[0].sfl));
        check("sb_nf_last", 32'(nfl_a[cur]), 32'(sb[0].nfl));
        if (out_rdy) begin
          void'(sb.pop_front());
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
      end
    end
  end

  // Streams stim into the DUT, pushing each row's pass-0 words and then its replays.
  task automatic send_words(input int id);
    exp_t row[$];
    int   j = 0;
    int   wait_c;
    while (stim.size() > 0) begin
      in_dat = stim.pop_front();
      in_v   = 1'b1;
      wait_c = 0;
      @(negedge aclk);
      while (!in_rdy_a[id] && wait_c < 200) begin
        wait_c++;
        @(negedge aclk);
      end
      if (!in_rdy_a[id]) timeout_fail("in_accept");
      row.push_back('{dat: in_dat, sfl: (j == SF_T[id] - 1), nfl: (NF_T[id] == 1)});
      sb.push_back(row[row.size() - 1]);
      if (j == SF_T[id] - 1) begin
        for (int p = 1; p < NF_T[id]; p++)
          for (int k = 0; k < row.size(); k++)
            sb.push_back('{dat: row[k].dat, sfl: row[k].sfl, nfl: (p == NF_T[id] - 1)});
        row.delete();
        j = 0;
      end else begin
        j++;
      end
      @(posedge aclk);
      #1;
    end
    in_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge aclk);
      n++;
    end
    if (sb.size() != 0) timeout_fail("drain");
    @(posedge aclk);
    #1;
    check("idle_after_drain", 32'(out_v_a[cur]), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    in_v    = 1'b0;
    mon_en  = 1'b0;
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    pops      = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  initial begin
    logic [7:0] w4[4];
    int         n;
    w4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 12; i++) begin
      tbl[i].v       = (i < 4);
      tbl[i].dat     = (i < 4) ? w4[i] : 8'h00;
      tbl[i].exp_rdy = (i < 4);
      tbl[i].exp_dat = w4[i % 4];
      tbl[i].exp_sfl = (i % 4 == 3);
      tbl[i].exp_nfl = (i >= 8);
    end

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst_in_rdy", 32'(in_rdy_a[0]), 32'd0);
    check("rst_out_v", 32'(out_v_a[0]), 32'd0);
    check("rst_out_dat", 32'(out_dat_a[0]), 32'd0);
    check("rst_sf_last", 32'(sfl_a[0]), 32'd0);
    check("rst_nf_last", 32'(nfl_a[0]), 32'd0);
    aresetn = 1'b1;

    // SF=4 NF=3: one row, cycle-exact from the vector table
    for (int i = 0; i < 12; i++) begin
      in_v   = tbl[i].v;
      in_dat = tbl[i].dat;
      @(negedge aclk);
      check("tbl_in_rdy", 32'(in_rdy_a[0]), 32'(tbl[i].exp_rdy));
      @(posedge aclk);
      #1;
      check("tbl_out_v", 32'(out_v_a[0]), 32'd1);
      check("tbl_out_dat", 32'(out_dat_a[0]), 32'(tbl[i].exp_dat));
      check("tbl_sf_last", 32'(sfl_a[0]), 32'(tbl[i].exp_sfl));
      check("tbl_nf_last", 32'(nfl_a[0]), 32'(tbl[i].exp_nfl));
    end
    in_v = 1'b0;

    // Two rows back-to-back: 24 outputs on consecutive cycles
    do_reset();
    cur    = 0;
    mon_en = 1'b1;
    stim   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_words(0);
    drain();
    check("two_rows_pops", 32'(pops), 32'd24);
    check("two_rows_no_gap", 32'(last_pop - first_pop), 32'd23);

    // Random out_rdy backpressure
    do_reset();
    mon_en = 1'b1;
    rnd_en = 1'b1;
    stim   = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_words(0);
    drain();
    rnd_en = 1'b0;
    @(posedge aclk);
    #2;
    out_rdy = 1'b1;
    check("rnd_pops", 32'(pops), 32'd12);

    // Reset during pass 2, then a fresh row
    do_reset();
    mon_en = 1'b1;
    stim   = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_words(0);
    n = 0;
    while (pops < 6 && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (pops < 6) timeout_fail("mid_pass2");
    aresetn = 1'b0;
    mon_en  = 1'b0;
    sb.delete();
    @(negedge aclk);
    check("midrst_in_rdy_low", 32'(in_rdy_a[0]), 32'd0);
    @(posedge aclk);
    #1;
    check("midrst_out_v", 32'(out_v_a[0]), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_in_rdy_high", 32'(in_rdy_a[0]), 32'd1);
    check("midrst_out_v_idle", 32'(out_v_a[0]), 32'd0);
    @(posedge aclk);
    #1;
    pops   = 0;
    mon_en = 1'b1;
    stim   = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_words(0);
    drain();
    check("midrst_pops", 32'(pops), 32'd12);

    // NF=1: 1-cycle pass-through, always ready, nf_last on every word
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_v   = 1'b1;
      in_dat = 8'h30 + 8'(i);
      @(negedge aclk);
      check("nf1_in_rdy", 32'(in_rdy_a[1]), 32'd1);
      @(posedge aclk);
      #1;
      check("nf1_out_v", 32'(out_v_a[1]), 32'd1);
      check("nf1_out_dat", 32'(out_dat_a[1]), 32'(8'h30 + 8'(i)));
      check("nf1_sf_last", 32'(sfl_a[1]), 32'(i % 4 == 3));
      check("nf1_nf_last", 32'(nfl_a[1]), 32'd1);
    end
    in_v = 1'b0;

    // SF=1 NF=2: every word twice, each one row-last
    do_reset();
    cur    = 2;
    mon_en = 1'b1;
    stim   = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_words(2);
    drain();
    check("sf1_pops", 32'(pops), 32'd8);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
